// File: rtl/sysid_regbank_if.sv
// Avalon-MM slave bus for the system ID register bank.
// Fixed read latency of one cycle, so the bus has no waitrequest.
interface sysid_regbank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank.sv
// System ID register bank: ID/timestamp words, a 64-bit uptime counter with
// LO-read-triggered HI snapshot, a CTRL register and byte-writable scratch words.
module sysid_regbank #(
  parameter logic [31:0] ID_VALUE    = 32'h63A27496,
  parameter logic [31:0] TIMESTAMP   = 32'h00000000,
  parameter int          NUM_SCRATCH = 4,
  parameter int          ADDR_W      = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  sysid_regbank_if.slave bus
);
  localparam logic [31:0] A_ID     = 32'd0;
  localparam logic [31:0] A_TSTAMP = 32'd1;
  localparam logic [31:0] A_UP_LO  = 32'd2;
  localparam logic [31:0] A_UP_HI  = 32'd3;
  localparam logic [31:0] A_CTRL   = 32'd4;
  localparam logic [31:0] A_SCR0   = 32'd5;

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snap_hi_q, snap_hi_d;
  logic        freeze_q, freeze_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q, readdatavalid_d;

  logic [ADDR_W-1:0] addr_w;
  logic [31:0]       addr_u;
  logic              rd_fire;
  logic              wr_ctrl;
  logic              clear_pulse;
  logic [31:0]       rd_word;

  assign addr_w = bus.address;
  assign addr_u = 32'(addr_w);

  always_comb begin
    // A write always wins over a simultaneous read; the read is dropped.
    rd_fire     = bus.read && !bus.write;
    wr_ctrl     = bus.write && (addr_u == A_CTRL) && bus.byteenable[0];
    clear_pulse = wr_ctrl && bus.writedata[1];
    freeze_d    = wr_ctrl ? bus.writedata[0] : freeze_q;

    if (clear_pulse) begin
      uptime_d = '0;
    end else if (!freeze_q) begin
      uptime_d = uptime_q + 64'd1;
    end else begin
      uptime_d = uptime_q;
    end

    scratch_d = scratch_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.write && (addr_u == A_SCR0 + 32'(i)) && bus.byteenable[b]) begin
          scratch_d[i][8*b +: 8] = bus.writedata[8*b +: 8];
        end
      end
    end

    rd_word = '0;
    case (addr_u)
      A_ID:     rd_word = ID_VALUE;
      A_TSTAMP: rd_word = TIMESTAMP;
      A_UP_LO:  rd_word = uptime_q[31:0];
      A_UP_HI:  rd_word = snap_hi_q;
      A_CTRL:   rd_word = {31'b0, freeze_q};
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (addr_u == A_SCR0 + 32'(i)) begin
            rd_word = scratch_q[i];
          end
        end
      end
    endcase

    // HI is captured from the same counter value the LO read returns.
    snap_hi_d       = (rd_fire && (addr_u == A_UP_LO)) ? uptime_q[63:32] : snap_hi_q;
    readdata_d      = rd_fire ? rd_word : readdata_q;
    readdatavalid_d = rd_fire;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q        <= '0;
      snap_hi_q       <= '0;
      freeze_q        <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      uptime_q        <= uptime_d;
      snap_hi_q       <= snap_hi_d;
      freeze_q        <= freeze_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;
endmodule

// File: tb/tb_sysid_regbank.sv
// Bench for sysid_regbank: vector table plus corner sequences, with read
// expectations queued at issue time and checked when readdatavalid arrives.
`timescale 1ns/1ps
module tb_sysid_regbank;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  sysid_regbank_if #(.ADDR_W(4)) bus ();

  sysid_regbank #(
    .ID_VALUE   (32'h63A27496),
    .TIMESTAMP  (32'h5EED0001),
    .NUM_SCRATCH(4),
    .ADDR_W     (4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    string       name;
  } exp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t        sb[$];
  exp_t        e;
  vec_t        tbl[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model of the spec-visible state.
  logic [63:0] m_cnt;
  logic        m_frz;
  logic [31:0] m_snap;
  logic        pend;
  logic [31:0] last_rd = 32'h0;
  bit          bd_load = 1'b0;
  logic [63:0] bd_val  = 64'h0;

  always @(posedge clock or negedge reset_n) begin : model
    logic wctl;
    wctl = bus.write && (bus.address == 4'd4) && bus.byteenable[0];
    if (!reset_n) begin
      m_cnt  <= 64'h0;
      m_frz  <= 1'b0;
      m_snap <= 32'h0;
      pend   <= 1'b0;
    end else begin
      pend <= bus.read && !bus.write;
      if (bus.read && !bus.write && bus.address == 4'd2) m_snap <= m_cnt[63:32];
      if (bd_load)                          m_cnt <= bd_val;
      else if (wctl && bus.writedata[1])    m_cnt <= 64'h0;
      else if (!m_frz)                      m_cnt <= m_cnt + 64'd1;
      if (wctl) m_frz <= bus.writedata[0];
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      checks++;
      if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: readdatavalid=%b readdata=%h, required 0 and 00000000",
                 bus.readdatavalid, bus.readdata);
      end
      last_rd = 32'h0;
    end else begin
      checks++;
      if (bus.readdatavalid !== pend) begin
        errors++;
        $display("FAIL readdatavalid: got %b, required %b at %0t", bus.readdatavalid, pend, $time);
      end
      if (bus.readdatavalid === 1'b1) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: readdata=%h with no read outstanding", bus.readdata);
        end else begin
          e = sb.pop_front();
          checks++;
          if ($isunknown(bus.readdata) || bus.readdata < e.lo || bus.readdata > e.hi) begin
            errors++;
            $display("FAIL %s: readdata=%h, required %h..%h", e.name, bus.readdata, e.lo, e.hi);
          end
        end
        last_rd = bus.readdata;
      end else begin
        checks++;
        if (bus.readdata !== last_rd) begin
          errors++;
          $display("FAIL readdata_hold: got %h, required %h", bus.readdata, last_rd);
        end
      end
    end
  end

  task automatic cyc(input bit rd, input bit wr, input logic [3:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] lo, input logic [31:0] hi,
                     input string nm);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = wd;
    if (rd && !wr) sb.push_back('{lo: lo, hi: hi, name: nm});
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 32'h0, 32'h0, "");
  endtask

  task automatic do_rd(input logic [3:0] a, input logic [31:0] ex, input string nm);
    cyc(1'b1, 1'b0, a, 4'h0, 32'h0, ex, ex, nm);
  endtask

  task automatic do_wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
    cyc(1'b0, 1'b1, a, be, wd, 32'h0, 32'h0, "");
  endtask

  initial begin
    tbl.push_back('{1, 0, 4'd0, 4'h0, 32'h0,        32'h63A27496, "id"});
    tbl.push_back('{1, 0, 4'd1, 4'h0, 32'h0,        32'h5EED0001, "tstamp"});
    tbl.push_back('{0, 1, 4'd5, 4'b0101, 32'hAABBCCDD, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd5, 4'h0, 32'h0,        32'h00BB00DD, "scr0_be0101"});
    tbl.push_back('{0, 1, 4'd0, 4'hF, 32'hFFFFFFFF, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd0, 4'h0, 32'h0,        32'h63A27496, "id_after_write"});
    tbl.push_back('{0, 1, 4'd1, 4'hF, 32'h12121212, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd1, 4'h0, 32'h0,        32'h5EED0001, "tstamp_after_write"});
    tbl.push_back('{0, 1, 4'd5, 4'h0, 32'h11111111, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd5, 4'h0, 32'h0,        32'h00BB00DD, "scr0_be0000"});
    tbl.push_back('{0, 1, 4'd5, 4'b1010, 32'h11223344, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd5, 4'h0, 32'h0,        32'h11BB33DD, "scr0_be1010"});
    tbl.push_back('{1, 1, 4'd6, 4'hF, 32'h12345678, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd6, 4'h0, 32'h0,        32'h12345678, "scr1_after_rdwr"});
    tbl.push_back('{0, 1, 4'd8, 4'hF, 32'hCAFEF00D, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd8, 4'h0, 32'h0,        32'hCAFEF00D, "scr3_last"});
    tbl.push_back('{0, 1, 4'd9, 4'hF, 32'hDEADBEEF, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd9, 4'h0, 32'h0,        32'h0,        "unmapped9"});
    tbl.push_back('{1, 0, 4'd15, 4'h0, 32'h0,       32'h0,        "unmapped15"});
    tbl.push_back('{1, 0, 4'd7, 4'h0, 32'h0,        32'h0,        "scr2_untouched"});
    tbl.push_back('{0, 1, 4'd4, 4'hF, 32'hFFFFFFFC, 32'h0, ""});
    tbl.push_back('{1, 0, 4'd4, 4'h0, 32'h0,        32'h0,        "ctrl_upper_bits"});

    reset_n        = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 4'd0;
    bus.byteenable = 4'h0;
    bus.writedata  = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Counter is 0 until the first edge after release, then counts.
    do_rd(4'd2, 32'h0, "uptime_first");
    do_rd(4'd2, 32'h1, "uptime_second");
    do_rd(4'd3, 32'h0, "uptime_hi_first");

    foreach (tbl[i]) begin
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].wd,
          tbl[i].exp, tbl[i].exp, tbl[i].name);
    end
    idle(2);

    // Freeze, clear while frozen, then release and let it run 10 cycles.
    do_wr(4'd4, 4'hF, 32'h1);
    do_wr(4'd4, 4'hF, 32'h3);
    idle(2);
    do_rd(4'd2, 32'h0, "lo_frozen_clear");
    do_rd(4'd3, 32'h0, "hi_frozen_clear");
    do_rd(4'd4, 32'h1, "ctrl_clear_reads_0");
    do_wr(4'd4, 4'hF, 32'h0);
    idle(10);
    cyc(1'b1, 1'b0, 4'd2, 4'h0, 32'h0, 32'd10, 32'd12, "lo_after_10");
    do_rd(4'd2, m_cnt[31:0], "lo_model");
    idle(2);

    // Preload near the 32-bit boundary while frozen, then run across it.
    do_wr(4'd4, 4'hF, 32'h1);
    bd_val  = 64'h0000_0000_FFFF_FFF8;
    bd_load = 1'b1;
    force dut.uptime_q = 64'h0000_0000_FFFF_FFF8;
    idle(1);
    release dut.uptime_q;
    bd_load = 1'b0;
    do_wr(4'd4, 4'hF, 32'h0);
    begin : wait_boundary
      int n;
      n = 0;
      while (m_cnt != 64'h0000_0000_FFFF_FFFF && n < 64) begin
        idle(1);
        n++;
      end
      checks++;
      if (n >= 64) begin
        errors++;
        $display("FAIL boundary_timeout: model count %h, required 00000000ffffffff", m_cnt);
      end
    end
    do_rd(4'd2, 32'hFFFFFFFF, "lo_pre_wrap");
    do_rd(4'd3, 32'h0,        "hi_snap_pre_wrap");
    do_rd(4'd2, m_cnt[31:0],  "lo_post_wrap");
    do_rd(4'd3, 32'h1,        "hi_snap_post_wrap");
    idle(2);

    // Reset arriving while a read result is on the bus.
    do_wr(4'd4, 4'hF, 32'h1);
    do_wr(4'd6, 4'hF, 32'hA5A5A5A5);
    do_rd(4'd6, 32'hA5A5A5A5, "scr1_pre_reset");
    reset_n = 1'b0;
    sb.delete();
    idle(2);
    reset_n = 1'b1;
    idle(3);
    do_rd(4'd6, 32'h0, "scr1_after_reset");
    do_rd(4'd4, 32'h0, "ctrl_after_reset");
    do_rd(4'd5, 32'h0, "scr0_after_reset");
    do_rd(4'd3, 32'h0, "hi_after_reset");
    idle(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads: %0d left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sysid_regbank.md
SYSID_REGBANK -- requirements
Module: sysid_regbank

Interface
REQ-001 Parameter ID_VALUE, default 32'h63A27496, system ID word returned at word 0.
REQ-002 Parameter TIMESTAMP, default 32'h00000000, build timestamp returned at word 1.
REQ-003 Parameter NUM_SCRATCH, default 4, range 1..8, number of 32-bit read/write scratch words.
REQ-004 Parameter ADDR_W, default 4, word-address width; SHALL satisfy 2**ADDR_W >= 5+NUM_SCRATCH.
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 address  in  ADDR_W  Avalon-MM word address.
REQ-008 read  in  1  read strobe, one access per cycle.
REQ-009 write  in  1  write strobe, one access per cycle.
REQ-010 byteenable  in  4  byte lanes for writes; ignored for reads.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  registered read data.
REQ-013 readdatavalid  out  1  one-cycle pulse qualifying readdata.

Function
REQ-014 Register map: 0 ID (RO) = ID_VALUE; 1 TSTAMP (RO) = TIMESTAMP; 2 UPTIME_LO (RO); 3 UPTIME_HI (RO, snapshot); 4 CTRL (RW); 5..4+NUM_SCRATCH SCRATCH[n] (RW).
REQ-015 Fixed read latency 1: read asserted in cycle N -> readdata valid and readdatavalid=1 in cycle N+1 only; no waitrequest.
REQ-016 readdata SHALL hold its last value when readdatavalid=0.
REQ-017 Unmapped reads -> readdata=0, readdatavalid=1.
REQ-018 Writes to RO or unmapped addresses SHALL be ignored without side effects.
REQ-019 read and write asserted together: write performed; read ignored; no readdatavalid pulse.
REQ-020 Uptime counter: 64-bit, increments by 1 every cycle while CTRL.FREEZE=0; wraps 2**64-1 -> 0 silently.
REQ-021 Reading UPTIME_LO returns counter[31:0] sampled in the read cycle and loads counter[63:32] from the same cycle into the HI snapshot register.
REQ-022 Reading UPTIME_HI returns the snapshot only; it SHALL NOT resample the counter.
REQ-023 CTRL bit0 FREEZE (RW, sticky): 1 holds the counter value.
REQ-024 CTRL bit1 CLEAR (write-1 self-clearing, reads 0): counter SHALL be 0 in the cycle after the write, then resume counting unless FREEZE=1; HI snapshot is not cleared.
REQ-025 CLEAR and FREEZE=1 written together: counter goes to 0 and holds.
REQ-026 CTRL bits 31:2 SHALL read 0 and ignore writes.
REQ-027 SCRATCH writes update only bytes whose byteenable bit is 1; byteenable=0000 is a no-op.
REQ-028 Write to a register followed by read of it in the next cycle SHALL return the new value.

Reset
REQ-029 reset_n=0 SHALL immediately force: readdata=0, readdatavalid=0, counter=0, HI snapshot=0, CTRL=0, all SCRATCH=0.
REQ-030 Reset asserted mid-access SHALL cancel any pending readdatavalid pulse; no output pulse after reset_n deasserts until a new read.
REQ-031 Counter SHALL begin incrementing on the first rising edge with reset_n=1.

Verification
REQ-032 Read address 0, then 1 -> readdata 32'h63A27496, then TIMESTAMP, each one cycle after read with readdatavalid=1.
REQ-033 Write CTRL=1 (freeze), preload via CLEAR, read LO then HI -> 0x00000000, 0x00000000; unfreeze, wait 10 cycles, read LO -> value in 10..12.
REQ-034 Force counter to 0x00000000_FFFFFFFF via run from clear with freeze timing (or backdoor); read LO=0xFFFFFFFF, then after wrap read HI -> 0 for first snapshot, 1 after a second LO read.
REQ-035 Write SCRATCH[0]=0xAABBCCDD with byteenable 0101, from 0 -> read 0x00BB00DD; write read-only address 0 -> read still 32'h63A27496.
REQ-036 Simultaneous read+write to SCRATCH[1]=0x12345678 -> no readdatavalid; next read returns 0x12345678; read address 15 -> 0.
REQ-037 Assert reset_n=0 in the cycle after a read -> readdatavalid stays 0, SCRATCH and CTRL read 0 after release.
